// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control encodings, default
// widths and the sequencing FSM state type.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOVE = 3'b010;
    localparam logic [2:0] ALU_SWAP = 3'b101;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SWAP2 = 1'b1
    } alu_state_e;

endpackage

// File: rtl/ex_alu_core.sv
// Purely combinational ALU: result, zero flag, signed overflow and illegal-code
// detection for one operation.
module ex_alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        code_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              illegal_o
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o  = '0;
        ovf_o     = 1'b0;
        illegal_o = 1'b0;
        unique case (code_i)
            ALU_ADD: begin
                result_o = sum;
                // Same-sign operands producing a different-sign sum overflowed.
                ovf_o    = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_SUB: begin
                result_o = diff;
                ovf_o    = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                           (diff[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_MOVE, ALU_SWAP: result_o = b_i;
            default:  illegal_o = 1'b1;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: one-cycle ALU with a registered EX/MEM slot. SWAP produces two
// write-backs on consecutive cycles and stalls upstream for the second one.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both 1 and flush is 0; upstream holds it while in_ready is 0.
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [REG_W-1:0]  rd_a,
    input  logic [REG_W-1:0]  rd_b,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_wreg,
    output logic              out_wen,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_illegal,
    output alu_state_e        dbg_state_o
);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] swap_a_q, swap_a_d;
    logic [REG_W-1:0]  swap_rd_q, swap_rd_d;

    logic              valid_d, wen_d, zero_d, ovf_d, illegal_d;
    logic [DATA_W-1:0] result_d;
    logic [REG_W-1:0]  wreg_d;

    logic              accept;
    logic              in_swap2;
    logic [2:0]        core_code;
    logic [DATA_W-1:0] core_b;
    logic [DATA_W-1:0] core_result;
    logic              core_zero, core_ovf, core_illegal;

    assign in_swap2    = (state_q == ST_SWAP2);
    assign in_ready    = ~in_swap2;
    assign accept      = in_valid & in_ready & ~flush;
    assign dbg_state_o = state_q;

    // The second SWAP write is a MOVE of the captured op_a through the core.
    assign core_code = in_swap2 ? ALU_MOVE : alu_control;
    assign core_b    = in_swap2 ? swap_a_q : op_b;

    ex_alu_core #(.DATA_W(DATA_W)) u_core (
        .code_i    (core_code),
        .a_i       (op_a),
        .b_i       (core_b),
        .result_o  (core_result),
        .zero_o    (core_zero),
        .ovf_o     (core_ovf),
        .illegal_o (core_illegal)
    );

    always_comb begin
        state_d   = ST_RUN;
        swap_a_d  = swap_a_q;
        swap_rd_d = swap_rd_q;
        valid_d   = 1'b0;
        wen_d     = 1'b0;
        result_d  = '0;
        wreg_d    = '0;
        zero_d    = 1'b0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;

        if (!flush) begin
            if (in_swap2) begin
                valid_d  = 1'b1;
                wen_d    = 1'b1;
                result_d = core_result;
                wreg_d   = swap_rd_q;
                zero_d   = core_zero;
            end else if (accept) begin
                valid_d   = 1'b1;
                wen_d     = ~core_illegal;
                result_d  = core_result;
                wreg_d    = rd_a;
                zero_d    = core_zero;
                ovf_d     = core_ovf;
                illegal_d = core_illegal;
                if (alu_control == ALU_SWAP) begin
                    state_d   = ST_SWAP2;
                    swap_a_d  = op_a;
                    swap_rd_d = rd_b;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            swap_a_q    <= '0;
            swap_rd_q   <= '0;
            out_valid   <= 1'b0;
            out_wen     <= 1'b0;
            out_result  <= '0;
            out_wreg    <= '0;
            out_zero    <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_a_q    <= swap_a_d;
            swap_rd_q   <= swap_rd_d;
            out_valid   <= valid_d;
            out_wen     <= wen_d;
            out_result  <= result_d;
            out_wreg    <= wreg_d;
            out_zero    <= zero_d;
            out_ovf     <= ovf_d;
            out_illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: a table of single-cycle ops applied
// back-to-back, plus hand-written SWAP, flush and reset sequences.
module tb_ex_alu_stage;
    import alu_pkg::*;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        alu_control;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  rd_a;
    logic [REG_W-1:0]  rd_b;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_wreg;
    logic              out_wen;
    logic              out_zero;
    logic              out_ovf;
    logic              out_illegal;
    alu_state_e        dbg_state_o;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [2:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rda;
        logic [DATA_W-1:0] exp_result;
        logic              exp_ovf;
        logic              exp_zero;
        logic              exp_wen;
        logic              exp_illegal;
    } vec_t;

    vec_t vecs[14];

    ex_alu_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_wreg    (out_wreg),
        .out_wen     (out_wen),
        .out_zero    (out_zero),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal),
        .dbg_state_o (dbg_state_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, outputs sampled 1ns after rising edge
    task automatic drive(input logic v, input logic [2:0] c, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [REG_W-1:0] ra,
                         input logic [REG_W-1:0] rb, input logic fl);
        @(negedge clk);
        in_valid    = v;
        alu_control = c;
        op_a        = a;
        op_b        = b;
        rd_a        = ra;
        rd_b        = rb;
        flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [DATA_W-1:0] res,
                             input logic [REG_W-1:0] wreg, input logic rdy);
        chk({tag, ".valid"},  32'(out_valid), 32'd1);
        chk({tag, ".wen"},    32'(out_wen), 32'd1);
        chk({tag, ".result"}, 32'(out_result), 32'(res));
        chk({tag, ".wreg"},   32'(out_wreg), 32'(wreg));
        chk({tag, ".ovf"},    32'(out_ovf), 32'd0);
        chk({tag, ".zero"},   32'(out_zero), 32'(res == '0));
        chk({tag, ".ready"},  32'(in_ready), 32'(rdy));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".wen"},   32'(out_wen), 32'd0);
        chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            ctrl    a         b         rd    result    ovf   zero  wen   ill
        vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 4'd2, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b000, 16'h0001, 16'h0002, 4'd1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b000, 16'hFFFF, 16'h0001, 4'd4, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b000, 16'h8000, 16'h8000, 4'd5, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'b001, 16'h1234, 16'h1234, 4'd6, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{3'b001, 16'h8000, 16'h0001, 4'd7, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b001, 16'h0000, 16'h0001, 4'd8, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{3'b001, 16'h7FFF, 16'hFFFF, 4'd9, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 16'h1111, 16'hBEEF, 4'hA, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{3'b010, 16'h7FFF, 16'h0000, 4'hB, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'b111, 16'h7FFF, 16'h0001, 4'hC, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{3'b011, 16'h1234, 16'h5678, 4'hD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{3'b100, 16'h8000, 16'h8000, 4'hE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b110, 16'h0001, 16'h0001, 4'hF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_control = 3'b000;
        op_a        = '0;
        op_b        = '0;
        rd_a        = '0;
        rd_b        = '0;
        flush       = 1'b0;
        #12;
        chk_idle("reset");
        chk("reset.result", 32'(out_result), 32'd0);
        chk("reset.state",  32'(dbg_state_o), 32'(ST_RUN));
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors back-to-back, one per cycle
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rda, 4'd0, 1'b0);
            step();
            chk($sformatf("vec%0d.valid", i),   32'(out_valid), 32'd1);
            chk($sformatf("vec%0d.result", i),  32'(out_result), 32'(vecs[i].exp_result));
            chk($sformatf("vec%0d.ovf", i),     32'(out_ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d.zero", i),    32'(out_zero), 32'(vecs[i].exp_zero));
            chk($sformatf("vec%0d.wen", i),     32'(out_wen), 32'(vecs[i].exp_wen));
            chk($sformatf("vec%0d.illegal", i), 32'(out_illegal), 32'(vecs[i].exp_illegal));
            if (vecs[i].exp_wen)
                chk($sformatf("vec%0d.wreg", i), 32'(out_wreg), 32'(vecs[i].rda));
            chk($sformatf("vec%0d.ready", i),   32'(in_ready), 32'd1);
        end
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
        step();
        chk_idle("idle");

        // SWAP with an ADD held behind it; ADD's op_a differs to prove capture
        drive(1'b1, ALU_SWAP, 16'h00AA, 16'h0055, 4'd3, 4'd7, 1'b0);
        step();
        chk_write("swap1", 16'h0055, 4'd3, 1'b0);
        chk("swap1.state", 32'(dbg_state_o), 32'(ST_SWAP2));
        drive(1'b1, ALU_ADD, 16'h0001, 16'h0002, 4'd5, 4'd9, 1'b0);
        step();
        chk_write("swap2", 16'h00AA, 4'd7, 1'b1);
        step();
        chk_write("held_add", 16'h0003, 4'd5, 1'b1);
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
        step();
        chk_idle("after_swap");

        // Flush during first SWAP write suppresses the second
        drive(1'b1, ALU_SWAP, 16'h1111, 16'h2222, 4'd1, 4'd2, 1'b0);
        step();
        chk_write("fswap1", 16'h2222, 4'd1, 1'b0);
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        step();
        chk_idle("fswap_flush");
        chk("fswap.state", 32'(dbg_state_o), 32'(ST_RUN));
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
        step();
        chk_idle("fswap_after");

        // Flush overrides an accept in RUN
        drive(1'b1, ALU_ADD, 16'h0004, 16'h0005, 4'd3, 4'd0, 1'b1);
        step();
        chk_idle("flush_accept");
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);

        // Asynchronous reset in the middle of SWAP2
        drive(1'b1, ALU_SWAP, 16'h0F0F, 16'hF0F0, 4'd4, 4'd8, 1'b0);
        step();
        chk_write("rswap1", 16'hF0F0, 4'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid.result", 32'(out_result), 32'd0);
        chk("rst_mid.wreg",   32'(out_wreg), 32'd0);
        chk("rst_mid.state",  32'(dbg_state_o), 32'(ST_RUN));
        drive(1'b0, 3'b000, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_idle("rst_release1");
        step();
        chk_idle("rst_release2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
